// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the fp_conv_arbiter block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp_conv_pkg;

  // Input sample width and floating-point field widths.
  localparam int DATA_W = 12;
  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;

  // Values used when a result overflows the representable range.
  localparam logic [EXP_W-1:0] E_MAX = 3'd7;
  localparam logic [SIG_W-1:0] F_MAX = 4'b1111;

  // Arbiter/converter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fp_conv_core.sv
// Converts a 12-bit two's-complement sample to (sign, 3-bit exponent, 4-bit significand).
// Latency: purely combinational.
// Backpressure: none; the caller holds the input stable.
// Ports: i_data (sample), o_s (sign), o_e (exponent), o_f (significand).
module fp_conv_core
  import fp_conv_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic              o_s,
  output logic [EXP_W-1:0]  o_e,
  output logic [SIG_W-1:0]  o_f
);

  logic [DATA_W-1:0] w_mag;
  logic [3:0]        w_msb;
  logic [SIG_W:0]    w_shf;
  logic [SIG_W:0]    w_rnd;
  logic [EXP_W-1:0]  w_e_raw;

  // Magnitude; the most negative sample has no positive twin, so clamp it.
  always_comb begin
    o_s = i_data[DATA_W-1];
    if (i_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
      w_mag = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (i_data[DATA_W-1]) begin
      w_mag = -i_data;
    end else begin
      w_mag = i_data;
    end
  end

  // Position of the leading one; the magnitude never reaches the top bit.
  always_comb begin
    w_msb = 4'd0;
    for (int i = 0; i < DATA_W-1; i++) begin
      if (w_mag[i]) w_msb = 4'(i);
    end
  end

  // w_shf holds the four significand bits in [4:1] and the round bit in [0].
  always_comb begin
    w_shf   = 5'(w_mag >> (w_msb - 4'd4));
    w_rnd   = {1'b0, w_shf[4:1]} + {4'b0000, w_shf[0]};
    w_e_raw = 3'(w_msb - 4'd3);
    o_e     = w_e_raw;
    o_f     = w_rnd[SIG_W-1:0];
    if (w_msb < 4'd4) begin
      // Small magnitudes are stored exactly with a zero exponent.
      o_e = '0;
      o_f = w_mag[SIG_W-1:0];
    end else if (w_rnd[SIG_W]) begin
      // Rounding overflowed the significand: renormalise, or saturate at the top.
      if (w_e_raw == E_MAX) begin
        o_e = E_MAX;
        o_f = F_MAX;
      end else begin
        o_e = w_e_raw + 3'd1;
        o_f = 4'b1000;
      end
    end
  end

endmodule

// File: rtl/fp_conv_arbiter.sv
// Round-robin shares one fixed-to-float converter between two sample requesters.
// Latency: accept at edge t, out_valid seen at edge t+2; at most one sample per 3 cycles.
// Backpressure: result held while out_ready is low; no requester is accepted until it is consumed.
// Ports: clk, rst_n; req0/req1 valid/data/ready; out valid/ready/id/s/e/f; conv_count.
module fp_conv_arbiter
  import fp_conv_pkg::*;
#(
  parameter int INIT_PRIO = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_id,
  output logic              out_s,
  output logic [EXP_W-1:0]  out_e,
  output logic [SIG_W-1:0]  out_f,
  output logic [CNT_W-1:0]  conv_count
);

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;
  logic [DATA_W-1:0] r_sample;
  logic              r_id;
  logic              r_out_valid;
  logic              r_out_id;
  logic              r_out_s;
  logic [EXP_W-1:0]  r_out_e;
  logic [SIG_W-1:0]  r_out_f;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_gnt_vld;
  logic              w_gnt_id;
  logic              w_accept;
  logic              w_consume;
  logic              w_req0_rdy;
  logic              w_req1_rdy;
  logic              w_s;
  logic [EXP_W-1:0]  w_e;
  logic [SIG_W-1:0]  w_f;

  // Pointer names the favoured requester; the other wins only when the favoured one is idle.
  always_comb begin
    w_gnt_vld = req0_valid | req1_valid;
    if (r_ptr) w_gnt_id = req1_valid ? 1'b1 : 1'b0;
    else       w_gnt_id = req0_valid ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_consume  = 1'b0;
    w_req0_rdy = 1'b0;
    w_req1_rdy = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_accept   = 1'b1;
          w_req0_rdy = ~w_gnt_id;
          w_req1_rdy = w_gnt_id;
          w_next     = CONV;
        end
      end
      CONV: w_next = HOLD;
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_consume = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  fp_conv_core u_core (
    .i_data (r_sample),
    .o_s    (w_s),
    .o_e    (w_e),
    .o_f    (w_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= INIT_PRIO[0];
      r_sample    <= '0;
      r_id        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_id    <= 1'b0;
      r_out_s     <= 1'b0;
      r_out_e     <= '0;
      r_out_f     <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_sample <= w_gnt_id ? req1_data : req0_data;
        r_id     <= w_gnt_id;
        r_ptr    <= ~w_gnt_id;
      end
      if (r_state == CONV) begin
        r_out_valid <= 1'b1;
        r_out_id    <= r_id;
        r_out_s     <= w_s;
        r_out_e     <= w_e;
        r_out_f     <= w_f;
      end
      if (w_consume) begin
        r_out_valid <= 1'b0;
        r_cnt       <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign req0_ready = w_req0_rdy;
  assign req1_ready = w_req1_rdy;
  assign out_valid  = r_out_valid;
  assign out_id     = r_out_id;
  assign out_s      = r_out_s;
  assign out_e      = r_out_e;
  assign out_f      = r_out_f;
  assign conv_count = r_cnt;

endmodule
